// File: rtl/llc_snoop_responder.sv
// llc_snoop_responder: snoop lookup in the LLC tag/MESI array, MESI downgrade and HITM writeback.
// Define LLC_SNOOP_STATS_EN to add the cnt_nohit/cnt_hit/cnt_hitm result counters.
module llc_snoop_responder #(
    parameter int ADDR_SIZE = 32,
    parameter int LINE_SIZE = 64,
    parameter int N_WAY = 16,
    parameter int NUM_SETS = 16384,
    localparam int OFFSET_SIZE = $clog2(LINE_SIZE),
    localparam int INDEX_SIZE = $clog2(NUM_SETS),
    localparam int TAG_SIZE = ADDR_SIZE - OFFSET_SIZE - INDEX_SIZE,
    localparam int WAY_W = $clog2(N_WAY),
    localparam int EW = 2 + TAG_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  snp_valid,
    output logic                  snp_ready,
    input  logic [1:0]            snp_op,
    input  logic [ADDR_SIZE-1:0]  snp_addr,
    output logic                  res_valid,
    output logic [1:0]            res_code,
    output logic                  tag_rd_en,
    output logic [INDEX_SIZE-1:0] tag_rd_idx,
    input  logic [N_WAY*EW-1:0]   tag_rd_data,
    output logic                  tag_wr_en,
    output logic [INDEX_SIZE-1:0] tag_wr_idx,
    output logic [WAY_W-1:0]      tag_wr_way,
    output logic [1:0]            tag_wr_mesi,
    output logic                  wb_req,
    output logic [ADDR_SIZE-1:0]  wb_addr,
    input  logic                  wb_ack
`ifdef LLC_SNOOP_STATS_EN
    ,
    output logic [31:0]           cnt_nohit,
    output logic [31:0]           cnt_hit,
    output logic [31:0]           cnt_hitm
`endif
);
    localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, COMPARE = 3'd2, UPDATE = 3'd3, WB = 3'd4, RESP = 3'd5;
    localparam logic [1:0] NOHIT = 2'b00, HIT = 2'b01, HITM = 2'b10;
    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10;
    localparam logic [1:0] OP_READ = 2'b00, OP_RFO = 2'b10, OP_INV = 2'b11;

    logic [2:0] state;
    logic [1:0] op_r, code_r, mesi_r;
    logic [ADDR_SIZE-OFFSET_SIZE-1:0] line_r;
    logic [WAY_W-1:0] way_r, hit_way;
    logic wb_r, hit, nxt_wr, nxt_wb, is_m, is_s, rd, rfo, inv;
    logic [1:0] hit_mesi, nxt_code, nxt_mesi;
    logic unused_offset;

    assign unused_offset = ^snp_addr[OFFSET_SIZE-1:0];

    // Descending scan so the lowest matching way is the one left standing.
    always_comb begin
        hit = 1'b0;
        hit_mesi = ST_I;
        hit_way = '0;
        for (int w = N_WAY - 1; w >= 0; w--) begin
            if (tag_rd_data[w*EW+TAG_SIZE +: 2] != ST_I &&
                tag_rd_data[w*EW +: TAG_SIZE] == line_r[ADDR_SIZE-OFFSET_SIZE-1:INDEX_SIZE]) begin
                hit = 1'b1;
                hit_mesi = tag_rd_data[w*EW+TAG_SIZE +: 2];
                hit_way = WAY_W'(w);
            end
        end
    end

    assign is_m = hit_mesi == ST_M;
    assign is_s = hit_mesi == ST_S;
    assign rd = op_r == OP_READ;
    assign rfo = op_r == OP_RFO;
    assign inv = op_r == OP_INV;
    assign nxt_code = !hit ? NOHIT : (rd || rfo) ? (is_m ? HITM : HIT) : (inv && is_s) ? HIT : NOHIT;
    assign nxt_mesi = (rfo || inv) ? ST_I : ST_S;
    assign nxt_wr = hit && ((rd && !is_s) || rfo || (inv && is_s));
    assign nxt_wb = hit && (rd || rfo) && is_m;

    assign snp_ready = state == IDLE;
    assign tag_rd_en = state == LOOKUP;
    assign tag_wr_en = state == UPDATE;
    assign wb_req = state == WB;
    assign res_valid = state == RESP;
    assign res_code = res_valid ? code_r : NOHIT;
    assign tag_rd_idx = line_r[INDEX_SIZE-1:0];
    assign tag_wr_idx = line_r[INDEX_SIZE-1:0];
    assign tag_wr_way = way_r;
    assign tag_wr_mesi = mesi_r;
    assign wb_addr = {line_r, {OFFSET_SIZE{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_r <= '0;
            line_r <= '0;
            code_r <= NOHIT;
            mesi_r <= ST_I;
            way_r <= '0;
            wb_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (snp_valid) begin
                    state <= LOOKUP;
                    op_r <= snp_op;
                    line_r <= snp_addr[ADDR_SIZE-1:OFFSET_SIZE];
                end
                LOOKUP: state <= COMPARE;
                COMPARE: begin
                    state <= nxt_wr ? UPDATE : RESP;
                    code_r <= nxt_code;
                    mesi_r <= nxt_mesi;
                    way_r <= hit_way;
                    wb_r <= nxt_wb;
                end
                UPDATE: state <= wb_r ? WB : RESP;
                WB: if (wb_ack) state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LLC_SNOOP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_nohit <= '0;
            cnt_hit <= '0;
            cnt_hitm <= '0;
        end else if (res_valid) begin
            cnt_nohit <= cnt_nohit + 32'(code_r == NOHIT);
            cnt_hit <= cnt_hit + 32'(code_r == HIT);
            cnt_hitm <= cnt_hitm + 32'(code_r == HITM);
        end
    end
`endif
endmodule

// File: tb/tb_llc_snoop_responder.sv
// tb_llc_snoop_responder: directed and random snoops against a tag-array model and MESI rule table.
module tb_llc_snoop_responder;
    logic clk = 1'b0, rst = 1'b1, snp_valid = 1'b0, wb_ack = 1'b0;
    logic snp_ready, res_valid, tag_rd_en, tag_wr_en, wb_req;
    logic [1:0] snp_op = 2'b00, res_code, tag_wr_mesi;
    logic [31:0] snp_addr = '0, wb_addr;
    logic [13:0] tag_rd_idx, tag_wr_idx;
    logic [3:0] tag_wr_way;
    logic [223:0] tag_rd_data;
`ifdef LLC_SNOOP_STATS_EN
    logic [31:0] cnt_nohit, cnt_hit, cnt_hitm;
`endif
    int vectors = 0, miscompares = 0;
    logic [223:0] mem [int];

    llc_snoop_responder dut (
        .clk(clk), .rst(rst), .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op),
        .snp_addr(snp_addr), .res_valid(res_valid), .res_code(res_code), .tag_rd_en(tag_rd_en),
        .tag_rd_idx(tag_rd_idx), .tag_rd_data(tag_rd_data), .tag_wr_en(tag_wr_en),
        .tag_wr_idx(tag_wr_idx), .tag_wr_way(tag_wr_way), .tag_wr_mesi(tag_wr_mesi),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack)
`ifdef LLC_SNOOP_STATS_EN
        , .cnt_nohit(cnt_nohit), .cnt_hit(cnt_hit), .cnt_hitm(cnt_hitm)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [223:0] rd_row(input logic [13:0] idx);
        return mem.exists(int'(idx)) ? mem[int'(idx)] : '0;
    endfunction

    always @(posedge clk) if (tag_rd_en) tag_rd_data <= rd_row(tag_rd_idx);

    task automatic set_way(input logic [13:0] idx, input int w, input logic [1:0] st, input logic [11:0] t);
        logic [223:0] row = rd_row(idx);
        row[w*14 +: 14] = {st, t};
        mem[int'(idx)] = row;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Snoop outcome from the MESI rule table; states M=10 E=11 S=01 I=00.
    task automatic model(input logic [1:0] op, input logic [31:0] a, output logic [1:0] code,
                         output bit wr, output logic [3:0] way, output logic [1:0] nm, output bit wb);
        logic [223:0] row = rd_row(a[19:6]);
        int hw = -1;
        logic [1:0] st;
        for (int w = 15; w >= 0; w--)
            if (row[w*14+12 +: 2] != 2'b00 && row[w*14 +: 12] == a[31:20]) hw = w;
        code = 2'b00; wr = 0; way = '0; nm = 2'b00; wb = 0;
        if (hw >= 0) begin
            st = row[hw*14+12 +: 2];
            way = 4'(hw);
            case ({op, st})
                4'b0010: begin nm = 2'b01; code = 2'b10; wr = 1; wb = 1; end
                4'b0011: begin nm = 2'b01; code = 2'b01; wr = 1; end
                4'b0001: code = 2'b01;
                4'b1010: begin nm = 2'b00; code = 2'b10; wr = 1; wb = 1; end
                4'b1011, 4'b1001, 4'b1101: begin nm = 2'b00; code = 2'b01; wr = 1; end
                default: code = 2'b00;
            endcase
        end
    endtask

    task automatic snoop(input logic [1:0] op, input logic [31:0] a, input int ackd, input int rst_at);
        logic [1:0] e_code, e_mesi, wr_mesi, res_c;
        logic [3:0] e_way, wr_way;
        bit e_wr, e_wb, aborted = 0, wb_unstable = 0;
        int rd_cyc = -1, wr_cnt = 0, wr_cyc = -1, wb_rise = -1, res_cyc = -1;
        logic [13:0] rd_idx = 'x;
        logic [31:0] wb_a = 'x;
        logic [223:0] row;
        model(op, a, e_code, e_wr, e_way, e_mesi, e_wb);
        @(negedge clk);
        chk("ready_idle", snp_ready, 1);
        snp_valid = 1; snp_op = op; snp_addr = a;
        @(posedge clk);
        #1 snp_valid = 0; snp_op = 2'($urandom); snp_addr = $urandom;
        for (int k = 1; k <= 60 && res_cyc < 0 && !aborted; k++) begin
            @(negedge clk);
            if (k == 1) chk("ready_busy", snp_ready, 0);
            if (tag_rd_en) begin rd_cyc = k; rd_idx = tag_rd_idx; end
            if (tag_wr_en) begin
                wr_cnt++; wr_cyc = k; wr_way = tag_wr_way; wr_mesi = tag_wr_mesi;
                chk("wr_idx", tag_wr_idx, a[19:6]);
            end
            if (wb_req) begin
                if (wb_rise < 0) begin wb_rise = k; wb_a = wb_addr; end
                else if (wb_addr !== wb_a) wb_unstable = 1;
                wb_ack = (k - wb_rise == ackd);
            end else wb_ack = $urandom_range(0, 1);
            if (res_valid) begin res_cyc = k; res_c = res_code; end
            if (k == rst_at) begin
                rst = 1; wb_ack = 0;
                @(negedge clk);
                chk("abort_wb_req", wb_req, 0);
                chk("abort_res_valid", res_valid, 0);
                chk("abort_tag_wr", tag_wr_en, 0);
                rst = 0; aborted = 1;
            end
        end
        wb_ack = 0;
        chk("rd_cycle", rd_cyc, 1);
        chk("rd_idx", rd_idx, a[19:6]);
        if (!aborted) begin
            chk("res_cycle", res_cyc, e_wb ? 5 + ackd : e_wr ? 4 : 3);
            chk("res_code", res_c, e_code);
        end
        chk("wr_count", wr_cnt, e_wr);
        if (e_wr) begin
            chk("wr_cycle", wr_cyc, 3);
            chk("wr_way", wr_way, e_way);
            chk("wr_mesi", wr_mesi, e_mesi);
            row = rd_row(a[19:6]);
            row[e_way*14+12 +: 2] = e_mesi;
            mem[int'(a[19:6])] = row;
        end
        chk("wb_seen", wb_rise >= 0, e_wb);
        if (e_wb) begin
            chk("wb_rise", wb_rise, 4);
            chk("wb_addr", wb_a, {a[31:6], 6'b0});
            chk("wb_stable", wb_unstable, 0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", snp_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_code", res_code, 0);
        chk("rst_rd_en", tag_rd_en, 0);
        chk("rst_wr_en", tag_wr_en, 0);
        chk("rst_wb_req", wb_req, 0);
        chk("rst_idx", {tag_rd_idx, tag_wr_idx, tag_wr_way, tag_wr_mesi}, 0);
        chk("rst_wb_addr", wb_addr, 0);
        rst = 0;
        snoop(2'b00, 32'h1234_5680, 0, 0);
        set_way(14'h55, 3, 2'b11, 12'h123);
        snoop(2'b00, {12'h123, 14'h55, 6'h11}, 0, 0);
        set_way(14'h66, 0, 2'b01, 12'h200);
        snoop(2'b00, {12'h200, 14'h66, 6'h0}, 0, 0);
        set_way(14'h1, 15, 2'b10, 12'hABC);
        set_way(14'h1, 4, 2'b11, 12'hABD);
        snoop(2'b10, 32'hABC0_0040, 2, 0);
        set_way(14'h77, 2, 2'b01, 12'h333);
        set_way(14'h77, 9, 2'b01, 12'h333);
        snoop(2'b11, {12'h333, 14'h77, 6'h0}, 0, 0);
        set_way(14'h88, 5, 2'b10, 12'h444);
        snoop(2'b11, {12'h444, 14'h88, 6'h0}, 0, 0);
        set_way(14'h99, 7, 2'b11, 12'h555);
        snoop(2'b01, {12'h555, 14'h99, 6'h0}, 0, 0);
        set_way(14'hAA, 1, 2'b10, 12'h666);
        snoop(2'b00, {12'h666, 14'hAA, 6'h0}, 20, 6);
`ifdef LLC_SNOOP_STATS_EN
        chk("cnt_clear", {cnt_nohit, cnt_hit, cnt_hitm}, 0);
`endif
        snoop(2'b00, 32'h1234_5680, 0, 0);
`ifdef LLC_SNOOP_STATS_EN
        chk("cnt_after", {cnt_nohit, cnt_hit, cnt_hitm}, {32'd1, 32'd0, 32'd0});
`endif
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 16; w++)
                set_way(14'(s), w, 2'($urandom_range(0, 3)), 12'h100 + 12'($urandom_range(0, 2)));
        for (int n = 0; n < 40; n++)
            snoop(2'($urandom), {12'h100 + 12'($urandom_range(0, 2)), 14'($urandom_range(0, 3)), 6'($urandom)},
                  $urandom_range(0, 3), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
